// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
//   Shared types and constants for the 8-bit calculator control path.
//   - ctrl_state_t : sequencing states of calc_ctrl
//   - OP_*         : operator keycodes produced by the operator keypad
//   - CALC_*       : default widths and timing
//   - is_valid_op  : true for keycodes the ALU understands (0x0-0xB)
// ---------------------------------------------------------------------------
package calc_pkg;

    localparam int CALC_DATA_W      = 8;
    localparam int CALC_DIGITS      = CALC_DATA_W / 4;
    localparam int CALC_ALU_TIMEOUT = 64;

    typedef enum logic [2:0] {
        S_OPA,
        S_OP,
        S_OPB,
        S_EXEC,
        S_RESULT,
        S_ERROR
    } ctrl_state_t;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_MUL = 4'h2;
    localparam logic [3:0] OP_DIV = 4'h3;
    localparam logic [3:0] OP_NOT = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_SHR = 4'h8;
    localparam logic [3:0] OP_SHL = 4'h9;
    localparam logic [3:0] OP_ASR = 4'hA;
    localparam logic [3:0] OP_ASL = 4'hB;

    function automatic logic is_valid_op(input logic [3:0] code);
        return code <= OP_ASL;
    endfunction

endpackage

// File: rtl/calc_operand_reg.sv
// ---------------------------------------------------------------------------
// calc_operand_reg
//   Hex-digit entry register for one operand: shifts digits in from the
//   right, stops accepting after DIGITS digits, and presents the value both
//   raw (for display) and with the sign flag applied (for the ALU).
//   clk, rst_n    : clock, asynchronous active-low reset
//   clear         : empty the register (value 0, no digits)
//   restart       : load a single digit as the first digit of a new entry
//   digit_valid   : a digit is offered this cycle
//   digit         : hex digit value
//   neg           : sign flag applied to signed_value
//   accept        : the offered digit is taken this cycle
//   raw           : unsigned entered value
//   signed_value  : two's complement negation of raw when neg is set
// ---------------------------------------------------------------------------
module calc_operand_reg
    import calc_pkg::*;
#(
    parameter int DATA_W = CALC_DATA_W,
    parameter int DIGITS = CALC_DIGITS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              restart,
    input  logic              digit_valid,
    input  logic [3:0]        digit,
    input  logic              neg,
    output logic              accept,
    output logic [DATA_W-1:0] raw,
    output logic [DATA_W-1:0] signed_value
);

    localparam int CW = $clog2(DIGITS + 1);

    logic [CW-1:0] count;

    assign accept = digit_valid && (count < CW'(DIGITS));

    // Wraps naturally in DATA_W bits, so the most negative value maps to itself.
    assign signed_value = neg ? -raw : raw;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw   <= '0;
            count <= '0;
        end else if (restart) begin
            raw   <= DATA_W'(digit);
            count <= CW'(1);
        end else if (clear) begin
            raw   <= '0;
            count <= '0;
        end else if (accept) begin
            raw   <= {raw[DATA_W-5:0], digit};
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/calc_ctrl.sv
// ---------------------------------------------------------------------------
// calc_ctrl
//   Sequencing FSM of the calculator: collects operand A, an operator and
//   operand B from the keypads, launches the ALU with a start/done handshake
//   and holds the result (or an error) for the display stage.
//   i_sys_clock, i_sys_reset : clock, asynchronous active-low reset
//   i_ctrl_digit_valid/digit : hex digit key pulse and value
//   i_ctrl_op_valid/keycode  : operator key pulse and code
//   i_ctrl_neg_flag          : level sign flag for the operand being closed
//   i_ctrl_equal             : "=" key pulse
//   i_ctrl_alu_done/result   : ALU completion pulse and result
//   o_ctrl_hex_new_input     : one pulse per accepted digit
//   o_ctrl_alu_start         : one-cycle ALU launch
//   o_ctrl_alu_op            : latched operator
//   o_ctrl_operand_a/b       : signed operands presented to the ALU
//   o_ctrl_display           : operand being entered, or the result
//   o_ctrl_result_valid      : high in S_RESULT
//   o_ctrl_error             : high in S_ERROR
// ---------------------------------------------------------------------------
module calc_ctrl
    import calc_pkg::*;
#(
    parameter int DATA_W      = CALC_DATA_W,
    parameter int DIGITS      = CALC_DIGITS,
    parameter int ALU_TIMEOUT = CALC_ALU_TIMEOUT
) (
    input  logic              i_sys_clock,
    input  logic              i_sys_reset,
    input  logic              i_ctrl_digit_valid,
    input  logic [3:0]        i_ctrl_digit,
    input  logic              i_ctrl_op_valid,
    input  logic [3:0]        i_ctrl_op_keycode,
    input  logic              i_ctrl_neg_flag,
    input  logic              i_ctrl_equal,
    input  logic              i_ctrl_alu_done,
    input  logic [DATA_W-1:0] i_ctrl_alu_result,
    output logic              o_ctrl_hex_new_input,
    output logic              o_ctrl_alu_start,
    output logic [3:0]        o_ctrl_alu_op,
    output logic [DATA_W-1:0] o_ctrl_operand_a,
    output logic [DATA_W-1:0] o_ctrl_operand_b,
    output logic [DATA_W-1:0] o_ctrl_display,
    output logic              o_ctrl_result_valid,
    output logic              o_ctrl_error
);

    localparam int TW = $clog2(ALU_TIMEOUT + 1);

    ctrl_state_t       state;
    logic [TW-1:0]     timer;
    logic [DATA_W-1:0] result;

    logic              digit_a, digit_b, restart_a, clear_b, op_ok;
    logic              accept_a, accept_b;
    logic [DATA_W-1:0] raw_a, raw_b, signed_a, signed_b;

    // A digit in the same cycle as an operator wins; the operator is dropped.
    assign op_ok     = i_ctrl_op_valid && !i_ctrl_digit_valid && is_valid_op(i_ctrl_op_keycode);
    assign digit_a   = (state == S_OPA) && i_ctrl_digit_valid;
    assign digit_b   = (state == S_OPB) && i_ctrl_digit_valid;
    assign restart_a = ((state == S_RESULT) || (state == S_ERROR)) && i_ctrl_digit_valid;
    // B is emptied whenever a fresh B entry is about to begin.
    assign clear_b   = (state == S_OP) || ((state == S_RESULT) && op_ok);

    calc_operand_reg #(.DATA_W(DATA_W), .DIGITS(DIGITS)) u_opa (
        .clk          (i_sys_clock),
        .rst_n        (i_sys_reset),
        .clear        (1'b0),
        .restart      (restart_a),
        .digit_valid  (digit_a),
        .digit        (i_ctrl_digit),
        .neg          (i_ctrl_neg_flag),
        .accept       (accept_a),
        .raw          (raw_a),
        .signed_value (signed_a)
    );

    calc_operand_reg #(.DATA_W(DATA_W), .DIGITS(DIGITS)) u_opb (
        .clk          (i_sys_clock),
        .rst_n        (i_sys_reset),
        .clear        (clear_b),
        .restart      (1'b0),
        .digit_valid  (digit_b),
        .digit        (i_ctrl_digit),
        .neg          (i_ctrl_neg_flag),
        .accept       (accept_b),
        .raw          (raw_b),
        .signed_value (signed_b)
    );

    always_ff @(posedge i_sys_clock or negedge i_sys_reset) begin
        if (!i_sys_reset) begin
            state                <= S_OPA;
            timer                <= '0;
            result               <= '0;
            o_ctrl_hex_new_input <= 1'b0;
            o_ctrl_alu_start     <= 1'b0;
            o_ctrl_alu_op        <= '0;
            o_ctrl_operand_a     <= '0;
            o_ctrl_operand_b     <= '0;
        end else begin
            o_ctrl_alu_start     <= 1'b0;
            o_ctrl_hex_new_input <= accept_a || accept_b || restart_a;

            case (state)
                S_OPA: begin
                    if (op_ok) begin
                        // Sign flag is sampled together with the operator key.
                        o_ctrl_operand_a <= signed_a;
                        o_ctrl_alu_op    <= i_ctrl_op_keycode;
                        state            <= S_OP;
                    end
                end

                S_OP: begin
                    if (o_ctrl_alu_op == OP_NOT) begin
                        o_ctrl_operand_b <= '0;
                        o_ctrl_alu_start <= 1'b1;
                        timer            <= '0;
                        state            <= S_EXEC;
                    end else begin
                        state <= S_OPB;
                    end
                end

                S_OPB: begin
                    if (op_ok) begin
                        o_ctrl_alu_op <= i_ctrl_op_keycode;
                    end else if (i_ctrl_equal && !i_ctrl_digit_valid) begin
                        o_ctrl_operand_b <= signed_b;
                        if ((o_ctrl_alu_op == OP_DIV) && (signed_b == '0)) begin
                            state <= S_ERROR;
                        end else begin
                            o_ctrl_alu_start <= 1'b1;
                            timer            <= '0;
                            state            <= S_EXEC;
                        end
                    end
                end

                S_EXEC: begin
                    if (i_ctrl_alu_done) begin
                        result <= i_ctrl_alu_result;
                        state  <= S_RESULT;
                    end else if (timer == TW'(ALU_TIMEOUT - 1)) begin
                        state <= S_ERROR;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                S_RESULT: begin
                    if (i_ctrl_digit_valid) begin
                        state <= S_OPA;
                    end else if (op_ok) begin
                        // Chained operation: the result becomes operand A.
                        o_ctrl_operand_a <= result;
                        o_ctrl_alu_op    <= i_ctrl_op_keycode;
                        state            <= S_OPB;
                    end
                end

                S_ERROR: begin
                    if (i_ctrl_digit_valid) begin
                        state <= S_OPA;
                    end
                end

                default: state <= S_OPA;
            endcase
        end
    end

    // NOTE: the default assignment at the top of always_comb guarantees every
    // path drives the output, so no latch can be inferred.
    always_comb begin
        o_ctrl_display = '0;
        case (state)
            S_OPA, S_OP:   o_ctrl_display = raw_a;
            S_OPB, S_EXEC: o_ctrl_display = raw_b;
            S_RESULT:      o_ctrl_display = result;
            default:       o_ctrl_display = '0;
        endcase
    end

    assign o_ctrl_result_valid = (state == S_RESULT);
    assign o_ctrl_error        = (state == S_ERROR);

endmodule

// File: tb/tb_calc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_calc_ctrl
//   Directed testbench for calc_ctrl: keypad sequences with hand-computed
//   operands, results, handshake timing and error conditions.
// ---------------------------------------------------------------------------
module tb_calc_ctrl;
    import calc_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       digit_valid, op_valid, neg_flag, equal, alu_done;
    logic [3:0] digit, op_keycode;
    logic [7:0] alu_result;
    logic       hex_new_input, alu_start, result_valid, error;
    logic [3:0] alu_op;
    logic [7:0] operand_a, operand_b, display;

    int errors = 0;
    int checks = 0;

    calc_ctrl dut (
        .i_sys_clock          (clk),
        .i_sys_reset          (rst_n),
        .i_ctrl_digit_valid   (digit_valid),
        .i_ctrl_digit         (digit),
        .i_ctrl_op_valid      (op_valid),
        .i_ctrl_op_keycode    (op_keycode),
        .i_ctrl_neg_flag      (neg_flag),
        .i_ctrl_equal         (equal),
        .i_ctrl_alu_done      (alu_done),
        .i_ctrl_alu_result    (alu_result),
        .o_ctrl_hex_new_input (hex_new_input),
        .o_ctrl_alu_start     (alu_start),
        .o_ctrl_alu_op        (alu_op),
        .o_ctrl_operand_a     (operand_a),
        .o_ctrl_operand_b     (operand_b),
        .o_ctrl_display       (display),
        .o_ctrl_result_valid  (result_valid),
        .o_ctrl_error         (error)
    );

    always #5 clk = ~clk;

    // Stimulus helpers: each is entered and left on a falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic key_digit(input logic [3:0] d);
        digit_valid = 1'b1; digit = d;
        @(negedge clk);
        digit_valid = 1'b0;
    endtask

    task automatic key_op(input logic [3:0] code, input logic neg);
        op_valid = 1'b1; op_keycode = code; neg_flag = neg;
        @(negedge clk);
        op_valid = 1'b0; neg_flag = 1'b0;
    endtask

    task automatic key_equal(input logic neg);
        equal = 1'b1; neg_flag = neg;
        @(negedge clk);
        equal = 1'b0; neg_flag = 1'b0;
    endtask

    task automatic alu_finish(input logic [7:0] r);
        alu_done = 1'b1; alu_result = r;
        @(negedge clk);
        alu_done = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        digit_valid = 1'b0; digit = '0; op_valid = 1'b0; op_keycode = '0;
        neg_flag = 1'b0; equal = 1'b0; alu_done = 1'b0; alu_result = '0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({hex_new_input, alu_start, alu_op, operand_a, operand_b, display, result_valid, error} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h %h %h %h %h %h %h %h want all zero", hex_new_input,
                     alu_start, alu_op, operand_a, operand_b, display, result_valid, error);
        end
        checks++;
        if (dut.state !== S_OPA) begin errors++; $display("FAIL reset_state: got %0d want %0d", dut.state, S_OPA); end
    endtask

    task automatic test_add();
        int starts = 0;
        key_digit(4'h1);
        checks++;
        if (hex_new_input !== 1'b1) begin errors++; $display("FAIL add_pulse: got %b want 1", hex_new_input); end
        key_digit(4'h2);
        checks++;
        if (display !== 8'h12) begin errors++; $display("FAIL add_disp_a: got %h want 12", display); end
        key_op(OP_ADD, 1'b0);
        tick(1);
        key_digit(4'h0);
        key_digit(4'h3);
        checks++;
        if (display !== 8'h03) begin errors++; $display("FAIL add_disp_b: got %h want 03", display); end
        key_equal(1'b0);
        for (int i = 0; i < 4; i++) begin
            if (alu_start) starts++;
            tick(1);
        end
        checks++;
        if (starts !== 1) begin errors++; $display("FAIL add_starts: got %0d want 1", starts); end
        checks++;
        if ({operand_a, operand_b, alu_op} !== {8'h12, 8'h03, 4'h0}) begin
            errors++; $display("FAIL add_operands: got %h %h %h want 12 03 0", operand_a, operand_b, alu_op);
        end
        alu_finish(8'h15);
        checks++;
        if ({display, result_valid} !== {8'h15, 1'b1}) begin
            errors++; $display("FAIL add_result: got %h %b want 15 1", display, result_valid);
        end
    endtask

    task automatic test_chain();
        key_op(OP_SUB, 1'b0);
        checks++;
        if ({operand_a, alu_op} !== {8'h15, OP_SUB} || dut.state !== S_OPB) begin
            errors++; $display("FAIL chain_op: got %h %h state %0d want 15 1 state %0d", operand_a, alu_op, dut.state, S_OPB);
        end
        key_digit(4'h5);
        key_equal(1'b0);
        checks++;
        if ({alu_start, operand_b} !== {1'b1, 8'h05}) begin
            errors++; $display("FAIL chain_start: got %b %h want 1 05", alu_start, operand_b);
        end
        alu_finish(8'h10);
        checks++;
        if (display !== 8'h10) begin errors++; $display("FAIL chain_result: got %h want 10", display); end
    endtask

    task automatic test_negative();
        key_digit(4'h0);
        checks++;
        if ({hex_new_input, display, result_valid} !== {1'b1, 8'h00, 1'b0} || dut.state !== S_OPA) begin
            errors++; $display("FAIL neg_restart: got %b %h %b state %0d want 1 00 0 state 0", hex_new_input, display, result_valid, dut.state);
        end
        key_digit(4'h5);
        key_op(OP_SUB, 1'b1);
        checks++;
        if (operand_a !== 8'hFB) begin errors++; $display("FAIL neg_opa: got %h want fb", operand_a); end
        tick(1);
        key_digit(4'h1);
        key_equal(1'b0);
        checks++;
        if ({alu_start, operand_b, alu_op} !== {1'b1, 8'h01, OP_SUB}) begin
            errors++; $display("FAIL neg_opb: got %b %h %h want 1 01 1", alu_start, operand_b, alu_op);
        end
        alu_finish(8'hFA);
    endtask

    task automatic test_not();
        key_digit(4'h9);
        key_op(OP_NOT, 1'b0);
        checks++;
        if ({alu_start, alu_op, operand_a} !== {1'b0, OP_NOT, 8'h09}) begin
            errors++; $display("FAIL not_latch: got %b %h %h want 0 4 09", alu_start, alu_op, operand_a);
        end
        tick(1);
        checks++;
        if ({alu_start, operand_b} !== {1'b1, 8'h00} || dut.state !== S_EXEC) begin
            errors++; $display("FAIL not_start: got %b %h state %0d want 1 00 state %0d", alu_start, operand_b, dut.state, S_EXEC);
        end
        tick(1);
        checks++;
        if (alu_start !== 1'b0) begin errors++; $display("FAIL not_single: got %b want 0", alu_start); end
        alu_finish(8'hF6);
        checks++;
        if (display !== 8'hF6) begin errors++; $display("FAIL not_result: got %h want f6", display); end
    endtask

    task automatic test_div_zero();
        int starts = 0;
        key_digit(4'h4);
        key_digit(4'h2);
        key_op(OP_DIV, 1'b0);
        tick(1);
        key_equal(1'b0);
        checks++;
        if ({error, display, operand_b} !== {1'b1, 8'h00, 8'h00}) begin
            errors++; $display("FAIL div0_error: got %b %h %h want 1 00 00", error, display, operand_b);
        end
        for (int i = 0; i < 4; i++) begin
            if (alu_start) starts++;
            tick(1);
        end
        checks++;
        if (starts !== 0) begin errors++; $display("FAIL div0_start: got %0d want 0", starts); end
        alu_finish(8'h33);
        checks++;
        if ({error, result_valid, display} !== {1'b1, 1'b0, 8'h00}) begin
            errors++; $display("FAIL div0_late_done: got %b %b %h want 1 0 00", error, result_valid, display);
        end
    endtask

    task automatic test_digit_limit();
        int pulses = 0;
        do_reset();
        key_digit(4'h1); if (hex_new_input) pulses++;
        key_digit(4'h2); if (hex_new_input) pulses++;
        key_digit(4'h3); if (hex_new_input) pulses++;
        checks++;
        if (pulses !== 2) begin errors++; $display("FAIL limit_pulses: got %0d want 2", pulses); end
        checks++;
        if (display !== 8'h12) begin errors++; $display("FAIL limit_display: got %h want 12", display); end
        key_op(4'hC, 1'b0);
        checks++;
        if (dut.state !== S_OPA || alu_op !== 4'h0) begin
            errors++; $display("FAIL invalid_op: got state %0d op %h want state 0 op 0", dut.state, alu_op);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        digit_valid = 1'b1; digit = 4'h7; op_valid = 1'b1; op_keycode = OP_ADD;
        tick(1);
        digit_valid = 1'b0; op_valid = 1'b0;
        checks++;
        if ({hex_new_input, display} !== {1'b1, 8'h07} || dut.state !== S_OPA) begin
            errors++; $display("FAIL simul_digit_wins: got %b %h state %0d want 1 07 state 0", hex_new_input, display, dut.state);
        end
    endtask

    task automatic test_neg_boundary();
        do_reset();
        key_digit(4'h8);
        key_digit(4'h0);
        key_op(OP_ADD, 1'b1);
        checks++;
        if (operand_a !== 8'h80) begin errors++; $display("FAIL neg_min: got %h want 80", operand_a); end
    endtask

    task automatic test_timeout();
        do_reset();
        key_digit(4'h1);
        key_op(OP_ADD, 1'b0);
        tick(1);
        key_digit(4'h1);
        key_equal(1'b0);
        checks++;
        if (alu_start !== 1'b1) begin errors++; $display("FAIL tmo_start: got %b want 1", alu_start); end
        tick(63);
        checks++;
        if (error !== 1'b0) begin errors++; $display("FAIL tmo_early: got %b want 0", error); end
        tick(1);
        checks++;
        if ({error, display, result_valid} !== {1'b1, 8'h00, 1'b0}) begin
            errors++; $display("FAIL tmo_error: got %b %h %b want 1 00 0", error, display, result_valid);
        end
    endtask

    task automatic test_reset_mid_exec();
        int starts = 0;
        key_digit(4'h2);
        key_op(OP_ADD, 1'b0);
        tick(1);
        key_digit(4'h3);
        key_equal(1'b0);
        tick(2);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({hex_new_input, alu_start, alu_op, operand_a, operand_b, display, result_valid, error} !== '0
            || dut.state !== S_OPA) begin
            errors++; $display("FAIL abort_outputs: got %b %b %h %h %h %h %b %b state %0d want all zero state 0", hex_new_input,
                               alu_start, alu_op, operand_a, operand_b, display, result_valid, error, dut.state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        alu_finish(8'h55);
        checks++;
        if ({result_valid, display} !== {1'b0, 8'h00} || dut.state !== S_OPA) begin
            errors++; $display("FAIL abort_late_done: got %b %h state %0d want 0 00 state 0", result_valid, display, dut.state);
        end
        for (int i = 0; i < 4; i++) begin
            if (alu_start) starts++;
            tick(1);
        end
        checks++;
        if (starts !== 0) begin errors++; $display("FAIL abort_start: got %0d want 0", starts); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_chain();
        test_negative();
        test_not();
        test_div_zero();
        test_digit_limit();
        test_simultaneous();
        test_neg_boundary();
        test_timeout();
        test_reset_mid_exec();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/calc_ctrl.md
Name: calc_ctrl

Overview:
- Central sequencing FSM of the 8-bit integer calculator.
- Collects operand A, an operator and operand B from the hex-digit keypad block and the operator keypad block (b_op).
- Applies the sign flag to each operand, launches the ALU with a start/done handshake, and holds the result or error for the display stage.
- Sits between the keypad front-ends and the ALU/display path. It is the only block that sequences the ALU.

Parameters:
- DATA_W, 8, operand/result width.
- DIGITS, 2, max hex digits per operand (DATA_W/4).
- ALU_TIMEOUT, 64, cycles to wait for i_ctrl_alu_done before flagging an error.

Ports:
- i_sys_clock  in  1  system clock.
- i_sys_reset  in  1  asynchronous, active-low reset.
- i_ctrl_digit_valid  in  1  one-cycle pulse: hex digit keyed.
- i_ctrl_digit  in  4  hex digit value, sampled only with valid.
- i_ctrl_op_valid  in  1  one-cycle pulse from b_op (o_b_op_valid_key_pressed).
- i_ctrl_op_keycode  in  4  operator code from b_op.
- i_ctrl_neg_flag  in  1  level sign flag from b_op.
- i_ctrl_equal  in  1  one-cycle pulse: "=" key.
- i_ctrl_alu_done  in  1  ALU completion pulse.
- i_ctrl_alu_result  in  DATA_W  ALU result, valid with done.
- o_ctrl_hex_new_input  out  1  one-cycle pulse per accepted digit; drives b_op i_b_op_hex_new_input.
- o_ctrl_alu_start  out  1  one-cycle ALU launch pulse.
- o_ctrl_alu_op  out  4  latched operator code.
- o_ctrl_operand_a  out  DATA_W  signed operand A.
- o_ctrl_operand_b  out  DATA_W  signed operand B.
- o_ctrl_display  out  DATA_W  value to show: the operand being entered, or the result.
- o_ctrl_result_valid  out  1  high while in S_RESULT.
- o_ctrl_error  out  1  high while in S_ERROR.

Behaviour:
Reset:
- All outputs are 0.
- State is S_OPA.
- Digit counter is 0.

States and transitions:
- S_OPA
  - On digit_valid with count < DIGITS: raw_a = {raw_a[3:0], digit}, count++, one-cycle hex_new_input pulse.
  - Digits beyond DIGITS are ignored, with no pulse.
  - On op_valid with a valid keycode (0x0-0xB), leave for S_OP.
- S_OP
  - Latch operand_a = neg_flag ? -raw_a : raw_a. The flag is sampled in the same cycle as op_valid.
  - Latch alu_op.
  - Clear the counter.
  - Unary NOT (0x4): go to S_EXEC with operand_b = 0.
  - Any other operator: go to S_OPB.
- S_OPB
  - Digit entry as in S_OPA into raw_b.
  - A new op_valid replaces alu_op and stays in S_OPB.
  - On equal: latch operand_b with neg_flag applied.
  - DIV (0x3) with operand_b == 0 goes to S_ERROR.
  - Otherwise go to S_EXEC.
- S_EXEC
  - Assert alu_start for exactly one cycle on entry, then wait.
  - On alu_done: latch the result into display and go to S_RESULT.
  - The timeout counter reaching ALU_TIMEOUT goes to S_ERROR.
- S_RESULT
  - A digit starts a new calculation: raw_a = digit, go to S_OPA.
  - op_valid chains: operand_a = result, latch the new op, go to S_OPB.
- S_ERROR
  - Display is 0.
  - Only a digit (restart into S_OPA) or reset exits.

Display:
- S_OPA shows raw_a.
- S_OPB shows raw_b.
- S_RESULT shows the result.

Boundary and simultaneous-event rules:
- Invalid keycodes (0xC-0xF) are ignored in every state.
- Digit and op in the same cycle: the digit has priority, and the op is dropped.
- Equal in S_OPB with zero digits entered: operand_b = 0.
- Negation is DATA_W two's complement; -0x80 stays 0x80.
- alu_done outside S_EXEC is ignored.
- Reset asserted mid-S_EXEC aborts immediately. No start pulse follows reset.

Decomposition:
- Package calc_pkg:
  - typedef enum ctrl_state_t {S_OPA, S_OP, S_OPB, S_EXEC, S_RESULT, S_ERROR}.
  - Op code constants: OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3, OP_NOT=4, OP_AND=5, OP_OR=6, OP_XOR=7, OP_SHR=8, OP_SHL=9, OP_ASR=A, OP_ASL=B.
  - DATA_W default.
- One sub-module: calc_operand_reg.
  - Digit shift register, counter and sign application.
  - Instantiated twice, for A and B.

Test Plan:
1. Digits 1,2, ADD, digits 0,3, equal, done with result 0x15:
   - operand_a=0x12, operand_b=0x03, alu_op=0.
   - Single start pulse.
   - display=0x15, result_valid=1.
2. Digits 0,5 with neg_flag=1 at op_valid, SUB, digit 1, equal -> operand_a=0xFB, operand_b=0x01.
3. Digits 4,2, DIV, equal with no B digits -> no alu_start, error=1, display=0x00.
4. Digits 1,2,3 -> raw_a=0x12, only two hex_new_input pulses.
5. NOT after digit A -> alu_start one cycle after the op latches, operand_b=0.
6. Start issued with done withheld for 64 cycles -> error=1.
7. Reset asserted (low) during S_EXEC -> all outputs 0, state S_OPA, late done ignored.
